core_ctrl: RTL and testbench

Instruction sequencer that drives one `core` through a full attention-row pass. It issues the 17-bit `inst` word plus the norm-memory and SFP strobes in the fixed order: Q load, K load, kernel load, execute, ofifo drain to psum memory, SFP sum, and SFP normalize into norm memory. It sits between the testbench or top-level host and a single core instance, and is the initiator for everything the core consumes.

---
 rtl/core_pkg.sv | 65 ++++++
 rtl/step_cnt.sv | 26 ++
 rtl/core_ctrl.sv | 170 +++++++++++++++++
 tb/tb_core_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core instruction sequencer:
// inst bit map, SFP codes, FSM states and the registered output bundle.
package core_pkg;

    localparam logic [4:0] COL        = 5'd8;
    localparam logic [4:0] DRAIN_WAIT = 5'd16;
    localparam logic [4:0] SFP_LAT    = 5'd2;
    localparam logic [4:0] N_MAX      = 5'd16;

    localparam int INST_W    = 17;
    localparam int I_OFIFO   = 16;
    localparam int I_QK_LSB  = 12;
    localparam int I_PS_LSB  = 8;
    localparam int I_EXE     = 7;
    localparam int I_KLD     = 6;
    localparam int I_QMEM_RD = 5;
    localparam int I_QMEM_WR = 4;
    localparam int I_KMEM_RD = 3;
    localparam int I_KMEM_WR = 2;
    localparam int I_PMEM_RD = 1;
    localparam int I_PMEM_WR = 0;

    localparam logic [1:0] SFP_IDLE = 2'b00;
    localparam logic [1:0] SFP_ACC  = 2'b01;
    localparam logic [1:0] SFP_DIV  = 2'b10;

    typedef enum logic [3:0] {
        IDLE, QWR, KWR, KLD, KBUB, EXE,
        WAIT, DRAIN, SUM, SWAIT, NORM, DONE
    } state_t;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              ld_req;
        logic              ld_is_k;
        logic [3:0]        ld_addr;
        logic [INST_W-1:0] inst;
        logic [3:0]        nm_addr;
        logic              nm_rd;
        logic              nm_wr;
        logic [1:0]        sfp;
        logic              fifo_rd;
        logic              wr_sum;
    } ctrl_out_t;

    function automatic logic [4:0] state_len(
        input state_t     s,
        input logic [4:0] n
    );
        case (s)
            QWR:     state_len = n;
            KWR:     state_len = COL;
            KLD:     state_len = COL;
            EXE:     state_len = n;
            WAIT:    state_len = DRAIN_WAIT;
            DRAIN:   state_len = n + 5'd1;
            SUM:     state_len = n + 5'd1;
            SWAIT:   state_len = SFP_LAT;
            NORM:    state_len = n + 5'd2;
            default: state_len = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/step_cnt.sv
// Per-state step counter: wraps to 0 on its terminal count,
// and is held at 0 while cleared.
module step_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic [4:0] len_i,
    output logic [4:0] cnt_o,
    output logic [4:0] nxt_o,
    output logic       tc_o
);

    logic [4:0] cnt_q;
    logic [4:0] cnt_d;

    assign tc_o  = (cnt_q == len_i - 5'd1);
    assign cnt_d = (clr_i || tc_o) ? 5'd0 : cnt_q + 5'd1;
    assign cnt_o = cnt_q;
    assign nxt_o = cnt_d;

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 5'd0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/core_ctrl.sv
// Sequencer for one core attention-row pass: load, execute,
// drain, SFP sum and normalize, plus idle norm-memory readback.
module core_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  n_rows,
    input  logic        rd_en,
    input  logic [3:0]  rd_addr,
    output logic        busy,
    output logic        done,
    output logic        ld_req,
    output logic        ld_is_k,
    output logic [3:0]  ld_addr,
    output logic [16:0] inst,
    output logic [3:0]  norm_mem_addr,
    output logic        norm_mem_rd,
    output logic        norm_mem_wr,
    output logic [1:0]  sfp_inst,
    output logic        fifo_ext_rd,
    output logic        wr_sum
);

    import core_pkg::*;

    state_t    state_q, state_d;
    logic [4:0] n_q, n_d;
    logic [4:0] cnt_q, cnt_d;
    logic       tc;
    logic       cnt_clr;
    logic [4:0] cnt_len;
    ctrl_out_t  out_q, out_d;

    assign cnt_clr = (state_q == IDLE);
    assign cnt_len = state_len(state_q, n_q);

    step_cnt u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (cnt_clr),
        .len_i (cnt_len),
        .cnt_o (cnt_q),
        .nxt_o (cnt_d),
        .tc_o  (tc)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = (n_rows > N_MAX) ? N_MAX : n_rows;
                    state_d = (n_rows == 5'd0) ? DONE : QWR;
                end
            end
            QWR:   if (tc) state_d = KWR;
            KWR:   if (tc) state_d = KLD;
            KLD:   if (tc) state_d = KBUB;
            KBUB:  state_d = EXE;
            EXE:   if (tc) state_d = WAIT;
            WAIT:  if (tc) state_d = DRAIN;
            DRAIN: if (tc) state_d = SUM;
            SUM:   if (tc) state_d = SWAIT;
            SWAIT: if (tc) state_d = NORM;
            NORM:  if (tc) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the next state so they line up with state_q.
    logic [3:0] c4, cm1, cm2;
    assign c4  = cnt_d[3:0];
    assign cm1 = c4 - 4'd1;
    assign cm2 = c4 - 4'd2;

    always_comb begin
        out_d      = '0;
        out_d.busy = (state_d != IDLE);
        unique case (state_d)
            IDLE: begin
                if (state_q == IDLE && rd_en) begin
                    out_d.nm_rd   = 1'b1;
                    out_d.nm_addr = rd_addr;
                end
            end
            QWR: begin
                out_d.inst[I_QMEM_WR]       = 1'b1;
                out_d.inst[I_QK_LSB +: 4]   = c4;
                out_d.ld_req                = 1'b1;
                out_d.ld_addr               = c4;
            end
            KWR: begin
                out_d.inst[I_KMEM_WR]       = 1'b1;
                out_d.inst[I_QK_LSB +: 4]   = c4;
                out_d.ld_req                = 1'b1;
                out_d.ld_is_k               = 1'b1;
                out_d.ld_addr               = c4;
            end
            KLD: begin
                out_d.inst[I_KMEM_RD]       = 1'b1;
                out_d.inst[I_KLD]           = 1'b1;
                out_d.inst[I_QK_LSB +: 4]   = c4;
            end
            EXE: begin
                out_d.inst[I_QMEM_RD]       = 1'b1;
                out_d.inst[I_EXE]           = 1'b1;
                out_d.inst[I_QK_LSB +: 4]   = c4;
            end
            DRAIN: begin
                if (cnt_d < n_d)
                    out_d.inst[I_OFIFO] = 1'b1;
                if (cnt_d >= 5'd1) begin
                    out_d.inst[I_PMEM_WR]     = 1'b1;
                    out_d.inst[I_PS_LSB +: 4] = cm1;
                end
            end
            SUM: begin
                if (cnt_d < n_d) begin
                    out_d.inst[I_PMEM_RD]     = 1'b1;
                    out_d.inst[I_PS_LSB +: 4] = c4;
                end
                if (cnt_d >= 5'd1)
                    out_d.sfp = SFP_ACC;
                out_d.wr_sum = (cnt_d == n_d);
            end
            SWAIT: out_d.fifo_rd = (cnt_d == 5'd0);
            NORM: begin
                if (cnt_d < n_d) begin
                    out_d.inst[I_PMEM_RD]     = 1'b1;
                    out_d.inst[I_PS_LSB +: 4] = c4;
                end
                if (cnt_d >= 5'd1 && cnt_d <= n_d)
                    out_d.sfp = SFP_DIV;
                if (cnt_d >= 5'd2) begin
                    out_d.nm_wr   = 1'b1;
                    out_d.nm_addr = cm2;
                end
            end
            DONE: out_d.done = 1'b1;
            default: out_d.busy = (state_d != IDLE);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= 5'd0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            out_q   <= out_d;
        end
    end

    assign busy          = out_q.busy;
    assign done          = out_q.done;
    assign ld_req        = out_q.ld_req;
    assign ld_is_k       = out_q.ld_is_k;
    assign ld_addr       = out_q.ld_addr;
    assign inst          = out_q.inst;
    assign norm_mem_addr = out_q.nm_addr;
    assign norm_mem_rd   = out_q.nm_rd;
    assign norm_mem_wr   = out_q.nm_wr;
    assign sfp_inst      = out_q.sfp;
    assign fifo_ext_rd   = out_q.fifo_rd;
    assign wr_sum        = out_q.wr_sum;

endmodule

// File: tb/tb_core_ctrl.sv
// Bench for core_ctrl: per-cycle expected output trace
// queued at start, popped and compared each cycle.
module tb_core_ctrl;

    localparam int COL = 8;
    localparam int DW  = 16;
    localparam int SL  = 2;

    logic        clk = 1'b0;
    logic        reset, start, rd_en;
    logic [4:0]  n_rows;
    logic [3:0]  rd_addr;
    logic        busy, done, ld_req, ld_is_k;
    logic [3:0]  ld_addr;
    logic [16:0] inst;
    logic [3:0]  norm_mem_addr;
    logic        norm_mem_rd, norm_mem_wr;
    logic [1:0]  sfp_inst;
    logic        fifo_ext_rd, wr_sum;

    always #5 clk = ~clk;

    core_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .n_rows        (n_rows),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .busy          (busy),
        .done          (done),
        .ld_req        (ld_req),
        .ld_is_k       (ld_is_k),
        .ld_addr       (ld_addr),
        .inst          (inst),
        .norm_mem_addr (norm_mem_addr),
        .norm_mem_rd   (norm_mem_rd),
        .norm_mem_wr   (norm_mem_wr),
        .sfp_inst      (sfp_inst),
        .fifo_ext_rd   (fifo_ext_rd),
        .wr_sum        (wr_sum)
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        ld_req;
        logic        ld_is_k;
        logic [3:0]  ld_addr;
        logic [16:0] inst;
        logic [3:0]  nm_addr;
        logic        nm_rd;
        logic        nm_wr;
        logic [1:0]  sfp;
        logic        fifo;
        logic        wr_sum;
    } rec_t;

    typedef struct {
        logic [4:0] n_in;
        int         exp_n;
        int         exp_busy;
    } vec_t;

    rec_t exp_q[$];
    vec_t vt[6];
    int   tests = 0;
    int   fails = 0;

    function automatic rec_t observe();
        rec_t r;
        r.busy    = busy;
        r.done    = done;
        r.ld_req  = ld_req;
        r.ld_is_k = ld_is_k;
        r.ld_addr = ld_addr;
        r.inst    = inst;
        r.nm_addr = norm_mem_addr;
        r.nm_rd   = norm_mem_rd;
        r.nm_wr   = norm_mem_wr;
        r.sfp     = sfp_inst;
        r.fifo    = fifo_ext_rd;
        r.wr_sum  = wr_sum;
        return r;
    endfunction

    task automatic check(input string tag, input int cyc, input rec_t e);
        rec_t g;
        g = observe();
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, g, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_pass(input int nn);
        rec_t r;
        if (nn > 0) begin
            for (int i = 0; i < nn; i++) begin
                r = '0; r.busy = 1'b1;
                r.inst[4] = 1'b1; r.inst[15:12] = 4'(i);
                r.ld_req = 1'b1; r.ld_addr = 4'(i);
                exp_q.push_back(r);
            end
            for (int i = 0; i < COL; i++) begin
                r = '0; r.busy = 1'b1;
                r.inst[2] = 1'b1; r.inst[15:12] = 4'(i);
                r.ld_req = 1'b1; r.ld_is_k = 1'b1; r.ld_addr = 4'(i);
                exp_q.push_back(r);
            end
            for (int i = 0; i < COL; i++) begin
                r = '0; r.busy = 1'b1;
                r.inst[3] = 1'b1; r.inst[6] = 1'b1;
                r.inst[15:12] = 4'(i);
                exp_q.push_back(r);
            end
            r = '0; r.busy = 1'b1;
            exp_q.push_back(r);
            for (int i = 0; i < nn; i++) begin
                r = '0; r.busy = 1'b1;
                r.inst[5] = 1'b1; r.inst[7] = 1'b1;
                r.inst[15:12] = 4'(i);
                exp_q.push_back(r);
            end
            for (int i = 0; i < DW; i++) begin
                r = '0; r.busy = 1'b1;
                exp_q.push_back(r);
            end
            for (int i = 0; i <= nn; i++) begin
                r = '0; r.busy = 1'b1;
                if (i < nn) r.inst[16] = 1'b1;
                if (i >= 1) begin
                    r.inst[0] = 1'b1; r.inst[11:8] = 4'(i - 1);
                end
                exp_q.push_back(r);
            end
            for (int i = 0; i <= nn; i++) begin
                r = '0; r.busy = 1'b1;
                if (i < nn) begin
                    r.inst[1] = 1'b1; r.inst[11:8] = 4'(i);
                end
                if (i >= 1) r.sfp = 2'b01;
                r.wr_sum = (i == nn);
                exp_q.push_back(r);
            end
            for (int i = 0; i < SL; i++) begin
                r = '0; r.busy = 1'b1;
                r.fifo = (i == 0);
                exp_q.push_back(r);
            end
            for (int i = 0; i <= nn + 1; i++) begin
                r = '0; r.busy = 1'b1;
                if (i < nn) begin
                    r.inst[1] = 1'b1; r.inst[11:8] = 4'(i);
                end
                if (i >= 1 && i <= nn) r.sfp = 2'b10;
                if (i >= 2) begin
                    r.nm_wr = 1'b1; r.nm_addr = 4'(i - 2);
                end
                exp_q.push_back(r);
            end
        end
        r = '0; r.busy = 1'b1; r.done = 1'b1;
        exp_q.push_back(r);
        exp_q.push_back('0);
        exp_q.push_back('0);
    endtask

    task automatic run_pass(
        input string      tag,
        input logic [4:0] n,
        input int         nn,
        input int         exp_busy,
        input bit         poke,
        input bit         rd_busy,
        input int         rst_at
    );
        rec_t e;
        int   k = 0;
        int   nbusy = 0;
        int   ndone = 0;
        bit   was_rst = 1'b0;
        gen_pass(nn);
        n_rows = n;
        start  = 1'b1;
        step();
        start  = 1'b0;
        while (exp_q.size() > 0 && !was_rst) begin
            e = exp_q.pop_front();
            check(tag, k, e);
            if (busy) nbusy++;
            if (done) ndone++;
            start   = poke && (e.inst[7] || e.done);
            rd_en   = rd_busy && e.busy;
            rd_addr = 4'($urandom_range(15));
            if (k == rst_at) begin
                reset = 1'b1; start = 1'b0; rd_en = 1'b0;
                step();
                reset = 1'b0;
                check({tag, "_rst"}, k + 1, '0);
                exp_q.delete();
                was_rst = 1'b1;
            end else begin
                step();
                k++;
            end
        end
        start = 1'b0;
        rd_en = 1'b0;
        if (!was_rst) begin
            tests++;
            if (nbusy != exp_busy) begin
                fails++;
                $display("FAIL %s busy_cycles got=%0d exp=%0d",
                         tag, nbusy, exp_busy);
            end
            tests++;
            if (ndone != 1) begin
                fails++;
                $display("FAIL %s done_pulses got=%0d exp=1",
                         tag, ndone);
            end
        end
    endtask

    initial begin
        rec_t e;
        reset   = 1'b1;
        start   = 1'b0;
        rd_en   = 1'b0;
        n_rows  = 5'd0;
        rd_addr = 4'd0;
        step();
        step();
        check("reset", 0, '0);
        reset = 1'b0;
        step();
        check("idle", 0, '0);

        vt[0] = '{5'd4,  4,  60};
        vt[1] = '{5'd0,  0,  1};
        vt[2] = '{5'd20, 16, 120};
        vt[3] = '{5'd1,  1,  45};
        vt[4] = '{5'd16, 16, 120};
        vt[5] = '{5'd31, 16, 120};
        for (int v = 0; v < 6; v++) begin
            run_pass($sformatf("pass_n%0d", vt[v].n_in), vt[v].n_in,
                     vt[v].exp_n, vt[v].exp_busy, 1'b0, 1'b0, -1);
        end

        run_pass("exe_restart", 5'd4, 4, 60, 1'b1, 1'b0, -1);
        run_pass("rd_busy", 5'd3, 3, 55, 1'b0, 1'b1, -1);
        run_pass("drain_rst", 5'd4, 4, 60, 1'b0, 1'b0, 43);
        run_pass("after_rst", 5'd3, 3, 55, 1'b0, 1'b0, -1);

        rd_en   = 1'b1;
        rd_addr = 4'd5;
        step();
        rd_en   = 1'b0;
        e = '0; e.nm_rd = 1'b1; e.nm_addr = 4'd5;
        check("readback", 0, e);
        step();
        check("readback_end", 1, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
